// File: rtl/chan_dispatch.sv
// 32-channel write-side dispatcher: a tagged word is steered into its channel's holding slot.
// Optional macro CHAN_DISPATCH_OVERWRITE_EN: never back-pressure, overwrite full slots and count overwrites.
module chan_dispatch #(
  parameter int CH_W = 20,
  parameter int N_CH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_data,
  input  logic [4:0]                 in_sel,
  output logic [N_CH-1:0][CH_W-1:0]  ch_data,
  output logic [N_CH-1:0]            ch_valid,
  input  logic [N_CH-1:0]            ch_ack,
  output logic [5:0]                 occupancy,
  output logic [7:0]                 ovr_cnt
);

  logic [N_CH-1:0][CH_W-1:0] data_q, data_d;
  logic [N_CH-1:0]           valid_q, valid_d;
  logic [N_CH-1:0]           we;
  logic [5:0]                occ_q, occ_d;
  logic                      accept;

`ifdef CHAN_DISPATCH_OVERWRITE_EN
  assign in_ready = rst_n;
`else
  // A slot being acked this cycle frees up in time to take the new word.
  assign in_ready = rst_n && (!valid_q[in_sel] || ch_ack[in_sel]);
`endif

  assign accept = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slot
      assign we[gi] = accept && (in_sel == 5'(gi));

      always_comb begin
        valid_d[gi] = valid_q[gi];
        data_d[gi]  = data_q[gi];
        if (we[gi]) begin
          valid_d[gi] = 1'b1;
          data_d[gi]  = in_data;
        end else if (ch_ack[gi]) begin
          valid_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      occ_d = occ_d + 6'(valid_d[i]);
    end
  end

`ifdef CHAN_DISPATCH_OVERWRITE_EN
  logic [7:0] ovr_q, ovr_d;
  logic       overwrite;

  // Only a write landing on an occupied, un-acked slot loses a word.
  assign overwrite = accept && valid_q[in_sel] && !ch_ack[in_sel];

  always_comb begin
    ovr_d = ovr_q;
    if (overwrite && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign ch_valid  = valid_q;
  assign ch_data   = data_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_chan_dispatch.sv
// Directed bench for chan_dispatch; covers the default build and, when
// CHAN_DISPATCH_OVERWRITE_EN is defined, the overwrite/counter behaviour.
module tb_chan_dispatch;

`ifdef CHAN_DISPATCH_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [19:0]        in_data;
  logic [4:0]         in_sel;
  logic [31:0][19:0]  ch_data;
  logic [31:0]        ch_valid;
  logic [31:0]        ch_ack;
  logic [5:0]         occupancy;
  logic [7:0]         ovr_cnt;

  int total = 0;
  int bad   = 0;

  chan_dispatch #(.CH_W(20), .N_CH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ack    (ch_ack),
    .occupancy (occupancy),
    .ovr_cnt   (ovr_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; ch_ack = '0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    step();
    step();
    total++;
    if (ch_valid !== 32'h0 || occupancy !== 6'd0 || ovr_cnt !== 8'd0 || ch_data[7] !== 20'h0) begin
      bad++; $display("FAIL reset_state: valid=%h occ=%0d ovr=%0d d7=%h want 0/0/0/0",
                      ch_valid, occupancy, ovr_cnt, ch_data[7]);
    end
    rst_n = 1'b1;
    step();
    $display("reset: valid=%h occ=%0d", ch_valid, occupancy);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sel = 5'd7; in_data = 20'h12345;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (ch_valid !== 32'h0000_0080 || ch_data[7] !== 20'h12345 || occupancy !== 6'd1) begin
      bad++; $display("FAIL single_write: valid=%h d7=%h occ=%0d want 00000080/12345/1",
                      ch_valid, ch_data[7], occupancy);
    end
    $display("write ch7: valid=%h d7=%h occ=%0d", ch_valid, ch_data[7], occupancy);
    ch_ack = 32'h0000_0080;
    step();
    ch_ack = '0;
    total++;
    if (ch_valid !== 32'h0 || occupancy !== 6'd0 || ch_data[7] !== 20'h12345) begin
      bad++; $display("FAIL single_ack: valid=%h occ=%0d d7=%h want 0/0/12345",
                      ch_valid, occupancy, ch_data[7]);
    end
    $display("ack ch7: valid=%h occ=%0d d7=%h", ch_valid, occupancy, ch_data[7]);
  endtask

  task automatic test_fill();
    int rdy_bad = 0;
    int dat_bad = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_sel = 5'(i); in_data = 20'(i * 20'h00101 + 20'h00003);
      #1;
      if (in_ready !== 1'b1) rdy_bad++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (rdy_bad != 0) begin
      bad++; $display("FAIL fill_accept: %0d cycles with in_ready low, want 0", rdy_bad);
    end
    total++;
    if (occupancy !== 6'd32 || ch_valid !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL fill_full: occ=%0d valid=%h want 32/ffffffff", occupancy, ch_valid);
    end
    for (int i = 0; i < 32; i++) begin
      if (ch_data[i] !== 20'(i * 20'h00101 + 20'h00003)) dat_bad++;
    end
    total++;
    if (dat_bad != 0) begin
      bad++; $display("FAIL fill_data: %0d slots hold wrong data, want 0", dat_bad);
    end
    rdy_bad = 0;
    for (int i = 0; i < 32; i++) begin
      in_sel = 5'(i);
      #1;
      if (in_ready !== OVR) rdy_bad++;
    end
    total++;
    if (rdy_bad != 0) begin
      bad++; $display("FAIL full_ready: %0d selects with in_ready=%b, want 0 mismatches",
                      rdy_bad, !OVR);
    end
    $display("fill: occ=%0d valid=%h", occupancy, ch_valid);
    ch_ack = 32'hFFFF_FFFF;
    #1;
    total++;
    if (occupancy !== 6'd32) begin
      bad++; $display("FAIL full_ack_same_cycle_occ: got %0d want 32", occupancy);
    end
    step();
    ch_ack = '0;
    total++;
    if (occupancy !== 6'd0 || ch_valid !== 32'h0) begin
      bad++; $display("FAIL ack_all: occ=%0d valid=%h want 0/0", occupancy, ch_valid);
    end
    $display("ack all: occ=%0d valid=%h", occupancy, ch_valid);
  endtask

  task automatic test_back_to_back();
    // Same channel every cycle while acked, then distinct channels.
    int rdy_bad = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 5'd4; in_data = 20'(20'h00400 + k);
      ch_ack = (k == 0) ? 32'h0 : 32'h0000_0010;
      #1;
      if (in_ready !== 1'b1) rdy_bad++;
      step();
    end
    in_valid = 1'b0; ch_ack = '0;
    total++;
    if (rdy_bad != 0 || ch_data[4] !== 20'h00403 || ch_valid !== 32'h0000_0010 || occupancy !== 6'd1) begin
      bad++; $display("FAIL b2b_same: stalls=%0d d4=%h valid=%h occ=%0d want 0/00403/00000010/1",
                      rdy_bad, ch_data[4], ch_valid, occupancy);
    end
    $display("b2b same ch4: d4=%h occ=%0d", ch_data[4], occupancy);
    ch_ack = 32'h0000_0010;
    step();
    ch_ack = '0;
    total++;
    if (ch_valid !== 32'h0) begin
      bad++; $display("FAIL b2b_release: valid=%h want 0", ch_valid);
    end
  endtask

`ifndef CHAN_DISPATCH_OVERWRITE_EN
  task automatic test_stall();
    in_valid = 1'b1; in_sel = 5'd5; in_data = 20'h00111;
    step();
    in_data = 20'h00AAA;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_ready_c%0d: got %b want 0", c, in_ready);
      end
      step();
    end
    total++;
    if (ch_data[5] !== 20'h00111 || occupancy !== 6'd1) begin
      bad++; $display("FAIL stall_hold: d5=%h occ=%0d want 00111/1", ch_data[5], occupancy);
    end
    ch_ack = 32'h0000_0020;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0; ch_ack = '0;
    total++;
    if (ch_valid !== 32'h0000_0020 || ch_data[5] !== 20'h00AAA || occupancy !== 6'd1) begin
      bad++; $display("FAIL stall_accept: valid=%h d5=%h occ=%0d want 00000020/00aaa/1",
                      ch_valid, ch_data[5], occupancy);
    end
    $display("stall ch5: valid=%h d5=%h occ=%0d", ch_valid, ch_data[5], occupancy);
  endtask
`else
  task automatic test_overwrite();
    int rdy_bad = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'b1; in_sel = 5'd3; in_data = 20'(20'h30000 + k);
      #1;
      if (in_ready !== 1'b1) rdy_bad++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (rdy_bad != 0 || ch_data[3] !== 20'h3012B || ovr_cnt !== 8'd255 || occupancy !== 6'd1) begin
      bad++; $display("FAIL overwrite: stalls=%0d d3=%h ovr=%0d occ=%0d want 0/3012b/255/1",
                      rdy_bad, ch_data[3], ovr_cnt, occupancy);
    end
    $display("overwrite ch3 x300: d3=%h ovr=%0d occ=%0d", ch_data[3], ovr_cnt, occupancy);
    ch_ack = 32'h0000_0008;
    step();
    ch_ack = '0;
    in_valid = 1'b1; in_sel = 5'd5; in_data = 20'h00AAA;
    step();
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_ack_empty();
    // Only ch5 is occupied here; ch9 still holds its fill value.
    ch_ack = 32'h0000_0200;
    step();
    ch_ack = '0;
    total++;
    if (ch_valid !== 32'h0000_0020 || occupancy !== 6'd1 || ch_data[9] !== 20'h0090C
        || ch_data[5] !== 20'h00AAA) begin
      bad++; $display("FAIL ack_empty: valid=%h occ=%0d d9=%h d5=%h want 00000020/1/0090c/00aaa",
                      ch_valid, occupancy, ch_data[9], ch_data[5]);
    end
    $display("ack empty ch9: valid=%h occ=%0d", ch_valid, occupancy);
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 2; k++) begin
      in_valid = 1'b1; in_sel = 5'(k); in_data = 20'(20'h0B000 + k);
      step();
    end
    total++;
    if (occupancy !== 6'd3 || ch_valid !== 32'h0000_0026) begin
      bad++; $display("FAIL pre_reset_occ: occ=%0d valid=%h want 3/00000026", occupancy, ch_valid);
    end
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 5'd10; in_data = 20'hFFFFF; ch_ack = 32'h0000_0004;
    step();
    rst_n = 1'b1; in_valid = 1'b0; ch_ack = '0;
    total++;
    if (ch_valid !== 32'h0 || occupancy !== 6'd0 || ovr_cnt !== 8'd0 || ch_data[10] !== 20'h0
        || ch_data[5] !== 20'h0 || ch_data[1] !== 20'h0) begin
      bad++; $display("FAIL reset_mid: valid=%h occ=%0d ovr=%0d d10=%h d5=%h d1=%h want all 0",
                      ch_valid, occupancy, ovr_cnt, ch_data[10], ch_data[5], ch_data[1]);
    end
    $display("reset mid-op: valid=%h occ=%0d d10=%h", ch_valid, occupancy, ch_data[10]);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
`ifndef CHAN_DISPATCH_OVERWRITE_EN
    test_stall();
`else
    test_overwrite();
`endif
    test_ack_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_dispatch.md
# chan_dispatch

Sequential 32-channel dispatcher for the flow-control datapath; the write-side counterpart to the 32×20 channel select/encode path. It accepts a stream of 20-bit words, each tagged with a 5-bit destination index, over a valid/ready handshake. It decodes the index to a one-hot channel and registers the word into that channel's holding slot. Each slot stays valid until its consumer acknowledges it.

## Interface
- `CH_W`, default 20: data width per channel.
- `N_CH`, fixed 32: channel count; the index is 5 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  producer presents a word.
- `in_ready`  out  1  dispatcher can take the word this cycle.
- `in_data`  in  [19:0]  word to dispatch.
- `in_sel`  in  [4:0]  destination channel index, unsigned.
- `ch_data`  out  [31:0][19:0]  per-channel holding registers.
- `ch_valid`  out  [31:0]  per-channel slot-occupied flags.
- `ch_ack`  in  [31:0]  per-channel consumer acknowledge. Any number of bits may be high in the same cycle.
- `occupancy`  out  [5:0]  count of set `ch_valid` bits, range 0..32.
- `ovr_cnt`  out  [7:0]  saturating overwrite counter (see Configuration).

## Operation
- One clock, `clk`. Reset is synchronous and active-low on `rst_n`.
- Decode: the one-hot write enable is `we[i] = accept && (in_sel == i)`, where `accept = in_valid && in_ready`.
- Ready (default build): `in_ready = rst_n && (!ch_valid[in_sel] || ch_ack[in_sel])`. This is combinational from `in_sel`, `ch_valid` and `ch_ack`. A free slot, or a slot being acked this cycle, can take a word.
- On accept: `ch_data[in_sel] <= in_data` and `ch_valid[in_sel] <= 1`.
- On `ch_ack[i] && ch_valid[i]` with no write to slot i: `ch_valid[i] <= 0`. `ch_data[i]` holds its last value.
- Ack on a slot whose `ch_valid` is low is ignored. No state changes.
- Ack and write to the same slot in the same cycle: the slot stays valid with the new data. The old word counts as consumed.
- Words are never dropped in the default build. `in_valid` with `in_ready` low is a stall. The producer must hold `in_data` and `in_sel` stable until accepted.
- `occupancy` is a register updated each cycle to the popcount of next-state `ch_valid`. It always equals `popcount(ch_valid)`.
- Slots are independent. Consumer order is unconstrained, and there is no inter-channel arbitration.

## Timing
- Reset (`rst_n` low at an edge): `ch_valid` = 0, `ch_data` = 0, `occupancy` = 0, `ovr_cnt` = 0.
- `in_ready` is forced low while `rst_n` is low.
- Reset mid-operation discards all held words at that edge. An ack or write presented in the same cycle is ignored.
- Write latency is 1 cycle: if accepted at edge N, `ch_valid`/`ch_data` are visible after edge N.
- Release latency is 1 cycle: if acked at edge N, `ch_valid` is low after edge N.
- Sustained throughput to distinct channels is 1 word/cycle.
- Back-to-back writes to the same channel run at 1 word/cycle only if the consumer acks that channel every cycle. Otherwise the second write stalls until the ack.
- When all 32 slots are full with no acks, `in_ready` = 0 for any `in_sel` and `occupancy` = 32. A full slot plus a same-cycle ack keeps `occupancy` at 32.

## Configuration
- Macro: `CHAN_DISPATCH_OVERWRITE_EN`.
- Defined:
  - `in_ready = rst_n`, never back-pressured.
  - A write to a valid slot that is not acked this cycle replaces `ch_data`. `ch_valid` stays 1.
  - `ovr_cnt` increments by 1 on each such overwrite and saturates at 255.
  - Writes to acked or free slots do not count.
- Undefined: the stall behaviour above applies. `ovr_cnt` is held at 0, with no counter logic.

## Test plan
- Reset, then write 0x12345 to ch 7 -> after 1 edge, `ch_valid` = 0x00000080, `ch_data[7]` = 0x12345, `occupancy` = 1. Ack ch 7 -> `ch_valid` = 0, `occupancy` = 0, `ch_data[7]` still 0x12345.
- Write ch 0..31 on consecutive cycles with no acks -> accepted 1/cycle, `occupancy` = 32, `in_ready` = 0 for every `in_sel`. Assert `ch_ack` = 0xFFFFFFFF for one cycle -> `occupancy` = 0.
- Ch 5 full, write 0x00AAA to ch 5 with no ack -> `in_ready` = 0, stall held 3 cycles. Ack ch 5 on cycle 4 with the write still presented -> accepted that cycle, `ch_valid[5]` stays 1, `ch_data[5]` = 0x00AAA, `occupancy` unchanged.
- Ack ch 9 while `ch_valid[9]` = 0 -> no change to any output.
- Three slots full, pulse `rst_n` low for 1 cycle with `in_valid` = 1 -> all outputs 0 after that edge, and the presented word is not captured.
- With `CHAN_DISPATCH_OVERWRITE_EN`: write ch 3 a total of 300 times without ack -> `in_ready` stays 1, `ch_data[3]` = last word, `ovr_cnt` = 255 (saturated), `occupancy` = 1.
